// File: rtl/vfpu_prenorm_add.sv
// vfpu_prenorm_add: unpack, magnitude-order and align two IEEE operands for the add/sub adder; 2-cycle latency.
// Elastic valid/ready pipe holding outputs under backpressure; define VFPU_PRENORM_DENORM_EN to keep subnormals.
module vfpu_prenorm_add #(
  parameter int FP_EXP_WIDTH          = 8,
  parameter int FP_MANT_WIDTH         = 23,
  parameter int GUARD_BITS            = 3,
  parameter int FP_EXP_PRENORM_WIDTH  = FP_EXP_WIDTH + 2,
  parameter int FP_MANT_PRENORM_WIDTH = FP_MANT_WIDTH + 2 + GUARD_BITS
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  input  logic [FP_EXP_WIDTH+FP_MANT_WIDTH:0]    operandA_i,
  input  logic [FP_EXP_WIDTH+FP_MANT_WIDTH:0]    operandB_i,
  input  logic                                   sub_i,
  input  logic                                   inValid_i,
  output logic                                   inReady_o,
  output logic                                   signPreNorm_o,
  output logic                                   effSub_o,
  output logic [FP_EXP_PRENORM_WIDTH-1:0]        exponentPreNorm_o,
  output logic [FP_MANT_PRENORM_WIDTH-1:0]       mantLargePreNorm_o,
  output logic [FP_MANT_PRENORM_WIDTH-1:0]       mantSmallPreNorm_o,
  output logic                                   isNaN_o,
  output logic                                   isInf_o,
  output logic                                   outValid_o,
  input  logic                                   outReady_i
);

  localparam int E   = FP_EXP_WIDTH;
  localparam int M   = FP_MANT_WIDTH;
  localparam int MP  = FP_MANT_PRENORM_WIDTH;
  localparam int SHW = $clog2(MP);

  typedef struct packed {
    logic         sign;
    logic [E-1:0] exp;
    logic [M-1:0] frac;
    logic         hid;
    logic         zero;
    logic         nan;
    logic         inf;
  } op_t;

  typedef struct packed {
    logic         sign;
    logic         eff_sub;
    logic [E-1:0] exp_l;
    logic [E-1:0] diff;
    logic         hid_l;
    logic [M-1:0] frac_l;
    logic         hid_s;
    logic [M-1:0] frac_s;
    logic         nan;
    logic         inf;
  } s1_t;

  typedef struct packed {
    logic                            sign;
    logic                            eff_sub;
    logic [FP_EXP_PRENORM_WIDTH-1:0] exp;
    logic [MP-1:0]                   mant_l;
    logic [MP-1:0]                   mant_s;
    logic                            nan;
    logic                            inf;
  } s2_t;

  function automatic op_t unpack(input logic [E+M:0] raw, input logic flip);
    op_t          o;
    logic [E-1:0] e_raw;
    logic [M-1:0] f_raw;
    logic         e_zero;
    logic         e_max;
    logic         f_zero;
    e_raw  = raw[E+M-1:M];
    f_raw  = raw[M-1:0];
    e_zero = (e_raw == '0);
    e_max  = &e_raw;
    f_zero = (f_raw == '0);
    o.sign = raw[E+M] ^ flip;
    o.hid  = !e_zero;
    o.nan  = e_max & !f_zero;
    o.inf  = e_max & f_zero;
`ifdef VFPU_PRENORM_DENORM_EN
    // a subnormal sits at the scale of exponent 1, only without the hidden bit
    o.exp  = (e_zero && !f_zero) ? E'(1) : e_raw;
    o.frac = f_raw;
    o.zero = e_zero & f_zero;
`else
    o.exp  = e_raw;
    o.frac = e_zero ? '0 : f_raw;
    o.zero = e_zero;
`endif
    return o;
  endfunction

  // handshake
  logic s1_vld;
  logic s2_vld;
  logic s2_load;
  logic s1_load;

  assign s2_load   = !s2_vld | outReady_i;
  assign inReady_o = !s1_vld | s2_load;
  assign s1_load   = inValid_i & inReady_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (clear_i) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (inReady_o) s1_vld <= inValid_i;
      if (s2_load)   s2_vld <= s1_vld;
    end
  end

  // S1: unpack and order by magnitude
  op_t  op_a;
  op_t  op_b;
  logic a_larger;
  logic both_zero;
  logic eff_sub;
  s1_t  s1_nxt;
  s1_t  s1_q;

  always_comb begin
    op_a      = unpack(operandA_i, 1'b0);
    op_b      = unpack(operandB_i, sub_i);
    a_larger  = {op_a.exp, op_a.frac} >= {op_b.exp, op_b.frac};
    eff_sub   = op_a.sign ^ op_b.sign;
    both_zero = op_a.zero & op_b.zero;

    s1_nxt.eff_sub = eff_sub;
    // x + (-x) with both zero rounds to +0; equal-signed zeros keep their sign
    s1_nxt.sign    = both_zero ? (!eff_sub & op_a.sign & op_b.sign)
                               : (a_larger ? op_a.sign : op_b.sign);
    s1_nxt.exp_l   = a_larger ? op_a.exp  : op_b.exp;
    s1_nxt.diff    = a_larger ? (op_a.exp - op_b.exp) : (op_b.exp - op_a.exp);
    s1_nxt.hid_l   = a_larger ? op_a.hid  : op_b.hid;
    s1_nxt.frac_l  = a_larger ? op_a.frac : op_b.frac;
    s1_nxt.hid_s   = a_larger ? op_b.hid  : op_a.hid;
    s1_nxt.frac_s  = a_larger ? op_b.frac : op_a.frac;
    s1_nxt.nan     = op_a.nan | op_b.nan | (op_a.inf & op_b.inf & eff_sub);
    s1_nxt.inf     = (op_a.inf | op_b.inf) & !s1_nxt.nan;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      s1_q <= '0;
    else if (s1_load) s1_q <= s1_nxt;
  end

  // S2: align the smaller mantissa, folding every lost bit into the sticky position
  logic [MP-1:0]  mant_s_full;
  logic [MP-1:0]  mant_s_shr;
  logic [MP-1:0]  lost_mask;
  logic [31:0]    diff_ext;
  logic [SHW-1:0] sh_amt;
  s2_t            s2_nxt;
  s2_t            s2_q;

  always_comb begin
    mant_s_full    = {1'b0, s1_q.hid_s, s1_q.frac_s, {GUARD_BITS{1'b0}}};
    diff_ext       = 32'(s1_q.diff);
    sh_amt         = (diff_ext > 32'(MP - 1)) ? SHW'(MP - 1) : SHW'(diff_ext);
    mant_s_shr     = mant_s_full >> sh_amt;
    lost_mask      = ~({MP{1'b1}} << sh_amt);

    s2_nxt.sign    = s1_q.sign;
    s2_nxt.eff_sub = s1_q.eff_sub;
    s2_nxt.exp     = FP_EXP_PRENORM_WIDTH'(s1_q.exp_l);
    s2_nxt.mant_l  = {1'b0, s1_q.hid_l, s1_q.frac_l, {GUARD_BITS{1'b0}}};
    s2_nxt.mant_s  = {mant_s_shr[MP-1:1], mant_s_shr[0] | (|(mant_s_full & lost_mask))};
    s2_nxt.nan     = s1_q.nan;
    s2_nxt.inf     = s1_q.inf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                s2_q <= '0;
    else if (s2_load && s1_vld) s2_q <= s2_nxt;
  end

  assign outValid_o         = s2_vld;
  assign signPreNorm_o      = s2_q.sign;
  assign effSub_o           = s2_q.eff_sub;
  assign exponentPreNorm_o  = s2_q.exp;
  assign mantLargePreNorm_o = s2_q.mant_l;
  assign mantSmallPreNorm_o = s2_q.mant_s;
  assign isNaN_o            = s2_q.nan;
  assign isInf_o            = s2_q.inf;

  a_hold_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (outValid_o && !outReady_i && !clear_i) |=> (outValid_o && $stable(s2_q)));

endmodule

// File: tb/tb_vfpu_prenorm_add.sv
// Bench for vfpu_prenorm_add: vector table driven through a scoreboard queue,
// plus hand sequences for latency, backpressure, clear and mid-flight reset.
`timescale 1ns/1ps
module tb_vfpu_prenorm_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        sub = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        sign;
  logic        eff_sub;
  logic [9:0]  exp_pn;
  logic [27:0] ml_pn;
  logic [27:0] ms_pn;
  logic        is_nan;
  logic        is_inf;
  logic        out_vld;
  logic        out_rdy = 1'b1;

  vfpu_prenorm_add dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .operandA_i(op_a), .operandB_i(op_b), .sub_i(sub),
    .inValid_i(in_vld), .inReady_o(in_rdy),
    .signPreNorm_o(sign), .effSub_o(eff_sub), .exponentPreNorm_o(exp_pn),
    .mantLargePreNorm_o(ml_pn), .mantSmallPreNorm_o(ms_pn),
    .isNaN_o(is_nan), .isInf_o(is_inf),
    .outValid_o(out_vld), .outReady_i(out_rdy)
  );

  always #5 clk = ~clk;

  // lvl 0: every field checked; 1: sign and flags; 2: flags only
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        sg;
    logic        ef;
    logic [9:0]  ex;
    logic [27:0] ml;
    logic [27:0] ms;
    logic        nan;
    logic        inf;
    int          lvl;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];
  vec_t nul;
  vec_t cur;
  vec_t sb_q[$];
  logic accepted;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(int id, logic [31:0] a, logic [31:0] b, logic s, logic sg, logic ef,
                              int ex, logic [27:0] ml, logic [27:0] ms, logic nan, logic inf, int lvl);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.s = s; v.sg = sg; v.ef = ef; v.ex = 10'(ex);
    v.ml = ml; v.ms = ms; v.nan = nan; v.inf = inf; v.lvl = lvl;
    return v;
  endfunction

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", what, act, expv);
    end
  endtask

  task automatic cmp(input vec_t e);
    string t;
    t = $sformatf("vec%0d", e.id);
    if (e.lvl == 0) begin
      chk({t, ".eff_sub"}, 32'(eff_sub), 32'(e.ef));
      chk({t, ".exp"},     32'(exp_pn),  32'(e.ex));
      chk({t, ".mant_l"},  32'(ml_pn),   32'(e.ml));
      chk({t, ".mant_s"},  32'(ms_pn),   32'(e.ms));
    end
    if (e.lvl <= 1) chk({t, ".sign"}, 32'(sign), 32'(e.sg));
    chk({t, ".nan"}, 32'(is_nan), 32'(e.nan));
    chk({t, ".inf"}, 32'(is_inf), 32'(e.inf));
  endtask

  task automatic sample();
    vec_t e;
    #1;
    accepted = in_vld && in_rdy;
    if (clear) begin
      sb_q.delete();
      accepted = 1'b0;
    end else begin
      if (out_vld && out_rdy) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got exp=0x%0h mant_l=0x%0h required no output", exp_pn, ml_pn);
        end else begin
          e = sb_q.pop_front();
          cmp(e);
        end
      end else if (out_vld && sb_q.size() != 0 && sb_q[0].lvl == 0) begin
        chk($sformatf("vec%0d.hold_exp", sb_q[0].id), 32'(exp_pn), 32'(sb_q[0].ex));
        chk($sformatf("vec%0d.hold_mant_s", sb_q[0].id), 32'(ms_pn), 32'(sb_q[0].ms));
      end
      if (accepted) sb_q.push_back(cur);
    end
  endtask

  task automatic step(input logic v, input vec_t x, input logic r, input logic clr);
    @(negedge clk);
    in_vld = v; op_a = x.a; op_b = x.b; sub = x.s; out_rdy = r; clear = clr; cur = x;
    sample();
  endtask

  task automatic send(input vec_t x, input logic r, input logic rnd);
    int guard;
    guard = 0;
    do begin
      step(1'b1, x, rnd ? 1'($urandom_range(0, 1)) : r, 1'b0);
      guard++;
    end while (!accepted && guard < 64);
    if (!accepted) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout vec%0d: got no accept in 64 cycles, required accept", x.id);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      step(1'b0, nul, 1'b1, 1'b0);
      guard++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    tbl[0]  = mk(0,  32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 127, 28'h4000000, 28'h4000000, 1'b0, 1'b0, 0);
    tbl[1]  = mk(1,  32'h3F000000, 32'h3F800000, 1'b1, 1'b1, 1'b1, 127, 28'h4000000, 28'h2000000, 1'b0, 1'b0, 0);
    tbl[2]  = mk(2,  32'h3F800000, 32'h30800000, 1'b0, 1'b0, 1'b0, 127, 28'h4000000, 28'h0000001, 1'b0, 1'b0, 0);
    tbl[3]  = mk(3,  32'hC0400000, 32'h3F800000, 1'b0, 1'b1, 1'b1, 128, 28'h6000000, 28'h2000000, 1'b0, 1'b0, 0);
    tbl[4]  = mk(4,  32'h40000000, 32'h40000000, 1'b1, 1'b0, 1'b1, 128, 28'h4000000, 28'h4000000, 1'b0, 1'b0, 0);
    tbl[5]  = mk(5,  32'h41800000, 32'h3F800001, 1'b0, 1'b0, 1'b0, 131, 28'h4000000, 28'h0400001, 1'b0, 1'b0, 0);
    tbl[6]  = mk(6,  32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 0,   28'h0,       28'h0,       1'b0, 1'b0, 0);
    tbl[7]  = mk(7,  32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 0,   28'h0,       28'h0,       1'b0, 1'b0, 0);
    tbl[8]  = mk(8,  32'h00000000, 32'hBF800000, 1'b0, 1'b1, 1'b1, 127, 28'h4000000, 28'h0,       1'b0, 1'b0, 0);
    tbl[9]  = mk(9,  32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 0,   28'h0,       28'h0,       1'b1, 1'b0, 2);
    tbl[10] = mk(10, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 0,   28'h0,       28'h0,       1'b1, 1'b0, 2);
    tbl[11] = mk(11, 32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 0,   28'h0,       28'h0,       1'b0, 1'b1, 1);
`ifdef VFPU_PRENORM_DENORM_EN
    tbl[12] = mk(12, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1,   28'h0000008, 28'h0,       1'b0, 1'b0, 0);
`else
    tbl[12] = mk(12, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 0,   28'h0,       28'h0,       1'b0, 1'b0, 0);
`endif
    tbl[13] = mk(13, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 0,   28'h0,       28'h0,       1'b0, 1'b0, 0);
    tbl[14] = mk(14, 32'h3F800000, 32'h32000000, 1'b0, 1'b0, 1'b0, 127, 28'h4000000, 28'h0000001, 1'b0, 1'b0, 0);
    tbl[15] = mk(15, 32'hFF800000, 32'hBF800000, 1'b0, 1'b1, 1'b0, 0,   28'h0,       28'h0,       1'b0, 1'b1, 1);
    tbl[16] = mk(16, 32'h3F800000, 32'h7F800000, 1'b1, 1'b1, 1'b0, 0,   28'h0,       28'h0,       1'b0, 1'b1, 1);
    nul     = mk(-1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 28'h0, 28'h0, 1'b0, 1'b0, 2);
    cur     = nul;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_in_rdy",  32'(in_rdy),  32'd1);
    chk("rst_exp",     32'(exp_pn),  32'd0);
    chk("rst_mant_l",  32'(ml_pn),   32'd0);
    chk("rst_mant_s",  32'(ms_pn),   32'd0);
    chk("rst_sign",    32'(sign),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // two-cycle latency from accept
    send(tbl[0], 1'b1, 1'b0);
    step(1'b0, nul, 1'b1, 1'b0);
    chk("lat_cycle1_out_vld", 32'(out_vld), 32'd0);
    step(1'b0, nul, 1'b1, 1'b0);
    chk("lat_cycle2_out_vld", 32'(out_vld), 32'd1);
    drain();

    // table back to back, then with random downstream stalls
    for (int i = 0; i < NV; i++) send(tbl[i], 1'b1, 1'b0);
    drain();
    for (int i = 0; i < NV; i++) send(tbl[i], 1'b0, 1'b1);
    drain();

    // backpressure: four pairs against a stalled sink
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      step(idx < 4, tbl[(idx < 4) ? idx : 0], c >= 5, 1'b0);
      if (accepted) idx++;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp_in_rdy_c%0d", c), 32'(in_rdy), 32'd0);
        chk($sformatf("bp_out_vld_c%0d", c), 32'(out_vld), 32'd1);
      end
      if (c == 4) chk("bp_accepts_while_stalled", 32'(idx), 32'd2);
    end
    chk("bp_accepts_total", 32'(idx), 32'd4);
    drain();

    // clear with both stages full
    send(tbl[1], 1'b0, 1'b0);
    send(tbl[2], 1'b0, 1'b0);
    step(1'b0, nul, 1'b0, 1'b1);
    step(1'b0, nul, 1'b0, 1'b0);
    chk("clr_out_vld", 32'(out_vld), 32'd0);
    chk("clr_in_rdy",  32'(in_rdy),  32'd1);

    // clear coinciding with an accept drops that pair
    step(1'b1, tbl[3], 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, nul, 1'b1, 1'b0);
      chk($sformatf("clr_acc_out_vld_c%0d", c), 32'(out_vld), 32'd0);
    end

    // asynchronous reset with both stages full
    send(tbl[4], 1'b0, 1'b0);
    send(tbl[5], 1'b0, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    sb_q.delete();
    chk("rst_mid_out_vld", 32'(out_vld), 32'd0);
    chk("rst_mid_in_rdy",  32'(in_rdy),  32'd1);
    chk("rst_mid_mant_l",  32'(ml_pn),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, nul, 1'b1, 1'b0);
    chk("rst_after_out_vld", 32'(out_vld), 32'd0);
    send(tbl[3], 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
